compute_unit_pipe: RTL

COMPUTE_UNIT_PIPE -- requirements
Module: compute_unit_pipe

---
 rtl/compute_unit_pkg.sv | 34 +++
 rtl/cu_alu.sv | 54 +++++
 rtl/compute_unit_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/compute_unit_pkg.sv
// Shared opcode encoding, result-flag layout and opcode classification helpers
// for the compute unit pipeline.
package compute_unit_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LOAD = 4'h1,
      OP_ADD  = 4'h2,
      OP_SUB  = 4'h3,
      OP_AND  = 4'h4,
      OP_OR   = 4'h5,
      OP_NOT  = 4'h6,
      OP_XOR  = 4'h7,
      OP_SHL  = 4'h8,
      OP_SHR  = 4'h9,
      OP_CMP  = 4'hA
   } op_e;

   typedef struct packed {
      logic illegal;
      logic carry;
      logic zero;
   } flags_t;

   // LOAD through SHR are the only opcodes that commit to the register file.
   function automatic logic op_writes_rf(input logic [3:0] op);
      return (op >= OP_LOAD) && (op <= OP_SHR);
   endfunction

   function automatic logic op_emits_beat(input logic [3:0] op);
      return op != OP_NOP;
   endfunction

endpackage

// File: rtl/cu_alu.sv
// Combinational ALU: one result word plus carry/borrow and illegal-opcode
// indication for a single instruction.
module cu_alu
   import compute_unit_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] data,
   output logic              carry,
   output logic              illegal
);

   logic [DATA_W:0] wide;

   always_comb begin
      data    = '0;
      carry   = 1'b0;
      illegal = 1'b0;
      wide    = '0;
      case (op)
         OP_NOP:  data = '0;
         OP_LOAD: data = imm;
         OP_ADD: begin
            wide  = {1'b0, a} + {1'b0, b};
            data  = wide[DATA_W-1:0];
            carry = wide[DATA_W];
         end
         // The extra MSB of the widened difference is the unsigned borrow.
         OP_SUB, OP_CMP: begin
            wide  = {1'b0, a} - {1'b0, b};
            data  = wide[DATA_W-1:0];
            carry = wide[DATA_W];
         end
         OP_AND:  data = a & b;
         OP_OR:   data = a | b;
         OP_NOT:  data = ~a;
         OP_XOR:  data = a ^ b;
         OP_SHL: begin
            data  = {a[DATA_W-2:0], 1'b0};
            carry = a[DATA_W-1];
         end
         OP_SHR: begin
            data  = {1'b0, a[DATA_W-1:1]};
            carry = a[0];
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/compute_unit_pipe.sv
// Two-stage compute unit: S1 holds the accepted instruction, EX reads the
// register file, runs the ALU and loads the output register in one edge.
module compute_unit_pipe
   import compute_unit_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int NUM_REGS = 16,
   localparam int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [IDX_W-1:0]  in_tgt,
   input  logic [IDX_W-1:0]  in_src0,
   input  logic [IDX_W-1:0]  in_src1,
   input  logic [DATA_W-1:0] in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_tgt,
   output logic              out_zero,
   output logic              out_carry,
   output logic              out_illegal
);

   logic              s1_valid_q, s1_valid_d;
   logic [3:0]        s1_op_q,    s1_op_d;
   logic [IDX_W-1:0]  s1_tgt_q,   s1_tgt_d;
   logic [IDX_W-1:0]  s1_src0_q,  s1_src0_d;
   logic [IDX_W-1:0]  s1_src1_q,  s1_src1_d;
   logic [DATA_W-1:0] s1_imm_q,   s1_imm_d;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [IDX_W-1:0]  out_tgt_q,   out_tgt_d;
   flags_t            out_flags_q, out_flags_d;

   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic [DATA_W-1:0] rf_d [NUM_REGS];

   logic              advance;
   logic              accept;
   logic              execute;
   logic [DATA_W-1:0] alu_data;
   logic              alu_carry;
   logic              alu_illegal;

   assign advance  = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || advance;
   assign accept   = in_valid && in_ready;
   assign execute  = advance && s1_valid_q;

   cu_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op      (s1_op_q),
      .a       (rf_q[s1_src0_q]),
      .b       (rf_q[s1_src1_q]),
      .imm     (s1_imm_q),
      .data    (alu_data),
      .carry   (alu_carry),
      .illegal (alu_illegal)
   );

   // S1 is either refilled by a new accept or emptied once EX consumes it.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_tgt_d   = s1_tgt_q;
      s1_src0_d  = s1_src0_q;
      s1_src1_d  = s1_src1_q;
      s1_imm_d   = s1_imm_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_op_d    = in_op;
         s1_tgt_d   = in_tgt;
         s1_src0_d  = in_src0;
         s1_src1_d  = in_src1;
         s1_imm_d   = in_imm;
      end else if (advance) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_tgt_d   = out_tgt_q;
      out_flags_d = out_flags_q;
      if (advance) begin
         out_valid_d = 1'b0;
         if (execute && op_emits_beat(s1_op_q)) begin
            out_valid_d         = 1'b1;
            out_data_d          = alu_data;
            out_tgt_d           = s1_tgt_q;
            out_flags_d.illegal = alu_illegal;
            out_flags_d.carry   = alu_carry;
            out_flags_d.zero    = !alu_illegal && (alu_data == '0);
         end
      end
   end

   always_comb begin
      rf_d = rf_q;
      if (execute && op_writes_rf(s1_op_q)) begin
         rf_d[s1_tgt_q] = alu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_tgt_q    <= '0;
         s1_src0_q   <= '0;
         s1_src1_q   <= '0;
         s1_imm_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_tgt_q   <= '0;
         out_flags_q <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_tgt_q    <= s1_tgt_d;
         s1_src0_q   <= s1_src0_d;
         s1_src1_q   <= s1_src1_d;
         s1_imm_q    <= s1_imm_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_tgt_q   <= out_tgt_d;
         out_flags_q <= out_flags_d;
         rf_q        <= rf_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_tgt     = out_tgt_q;
   assign out_zero    = out_flags_q.zero;
   assign out_carry   = out_flags_q.carry;
   assign out_illegal = out_flags_q.illegal;

endmodule
